// File: rtl/rx_det_array.sv
// N-lane receiver-detect model: each lane runs an independent four-phase req/ack detect
// with a programmable charge time and bounded retries after a no-receiver result.
module rx_det_array #(
    parameter int unsigned LANES        = 4,
    parameter int unsigned DELAY_CYCLES = 500,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned RETRY_MAX    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LANES-1:0] rx_present,
    input  logic [LANES-1:0] rx_det_req,
    output logic [LANES-1:0] rx_det_ack,
    output logic [LANES-1:0] rx_det_vld,
    output logic             det_any,
    output logic             det_all,
    output logic [LANES-1:0] busy
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DELAY_CYCLES - 1);
    localparam int unsigned      RtyW    = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam logic [RtyW-1:0]  RtyMax  = RtyW'(RETRY_MAX);

    if (DELAY_CYCLES < 1 || 64'(DELAY_CYCLES) >= (64'd1 << CNT_W)) begin : g_param_err
        $error("rx_det_array: DELAY_CYCLES must be in [1, 2**CNT_W)");
    end

    typedef enum logic [1:0] {StIdle, StCharge, StWaitLow} state_e;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        state_e            state_q, state_d;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic [RtyW-1:0]   rty_q, rty_d;
        logic              ack_q, ack_d;
        logic              vld_q, vld_d;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            rty_d   = rty_q;
            ack_d   = 1'b0;
            vld_d   = vld_q;
            unique case (state_q)
                StIdle: begin
                    if (rx_det_req[i]) begin
                        state_d = StCharge;
                        cnt_d   = '0;
                        rty_d   = '0;
                    end
                end
                StCharge: begin
                    // Abort wins over a completion landing on the same edge.
                    if (!rx_det_req[i]) begin
                        state_d = StIdle;
                    end else if (cnt_q == CntLast) begin
                        if (rx_present[i]) begin
                            vld_d   = 1'b1;
                            ack_d   = 1'b1;
                            state_d = StWaitLow;
                        end else if (rty_q < RtyMax) begin
                            cnt_d = '0;
                            rty_d = rty_q + 1'b1;
                        end else begin
                            vld_d   = 1'b0;
                            ack_d   = 1'b1;
                            state_d = StWaitLow;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StWaitLow: begin
                    if (!rx_det_req[i]) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                rty_q   <= '0;
                ack_q   <= 1'b0;
                vld_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                rty_q   <= rty_d;
                ack_q   <= ack_d;
                vld_q   <= vld_d;
            end
        end

        assign rx_det_ack[i] = ack_q;
        assign rx_det_vld[i] = vld_q;
        assign busy[i]       = (state_q == StCharge);
    end

    assign det_any = |rx_det_vld;
    assign det_all = &rx_det_vld;

endmodule

// File: tb/tb_rx_det_array.sv
// Bench for rx_det_array: directed vector table, hand sequences for abort/retry/reset,
// then random traffic checked every cycle against an elapsed-time reference model.
module tb_rx_det_array;

    localparam int L = 4;
    localparam int D = 8;
    localparam int R = 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [L-1:0] rx_present = '0;
    logic [L-1:0] rx_det_req = '0;
    logic [L-1:0] rx_det_ack;
    logic [L-1:0] rx_det_vld;
    logic         det_any;
    logic         det_all;
    logic [L-1:0] busy;

    int total = 0;
    int bad   = 0;

    rx_det_array #(
        .LANES       (L),
        .DELAY_CYCLES(D),
        .CNT_W       (16),
        .RETRY_MAX   (R)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_present(rx_present),
        .rx_det_req(rx_det_req),
        .rx_det_ack(rx_det_ack),
        .rx_det_vld(rx_det_vld),
        .det_any   (det_any),
        .det_all   (det_all),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: lane phase plus the edge number at which its request was accepted.
    // Sample edges fall at start + D*a for attempt a = 1..R+1.
    int           ph[L];      // 0 idle, 1 measuring, 2 waiting for req low
    int           start[L];
    int           edge_n = 0;
    logic [L-1:0] m_ack = '0;
    logic [L-1:0] m_vld = '0;

    function automatic logic [L-1:0] m_busy();
        logic [L-1:0] b;
        for (int l = 0; l < L; l++) b[l] = (ph[l] == 1);
        return b;
    endfunction

    task automatic check(input string name, input logic [L-1:0] act, input logic [L-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic [L-1:0] q, input logic [L-1:0] p);
        edge_n++;
        if (r) begin
            for (int l = 0; l < L; l++) ph[l] = 0;
            m_ack = '0;
            m_vld = '0;
            return;
        end
        m_ack = '0;
        for (int l = 0; l < L; l++) begin
            if (ph[l] == 0) begin
                if (q[l]) begin
                    ph[l]    = 1;
                    start[l] = edge_n;
                end
            end else if (ph[l] == 1) begin
                if (!q[l]) begin
                    ph[l] = 0;
                end else if ((edge_n - start[l]) % D == 0) begin
                    if (p[l] || (edge_n - start[l]) / D == R + 1) begin
                        m_vld[l] = p[l];
                        m_ack[l] = 1'b1;
                        ph[l]    = 2;
                    end
                end
            end else if (!q[l]) begin
                ph[l] = 0;
            end
        end
    endtask

    task automatic step(input int n);
        logic         r;
        logic [L-1:0] q, p;
        for (int k = 0; k < n; k++) begin
            r = rst;
            q = rx_det_req;
            p = rx_present;
            @(posedge clk);
            model_edge(r, q, p);
            #1;
            check("model_ack", rx_det_ack, m_ack);
            check("model_vld", rx_det_vld, m_vld);
            check("model_busy", busy, m_busy());
            check("model_any", {3'b0, det_any}, {3'b0, |m_vld});
            check("model_all", {3'b0, det_all}, {3'b0, &m_vld});
        end
    endtask

    task automatic expect_out(input string name, input logic [L-1:0] a, input logic [L-1:0] v,
                              input logic [L-1:0] b);
        check({name, "_ack"}, rx_det_ack, a);
        check({name, "_vld"}, rx_det_vld, v);
        check({name, "_busy"}, busy, b);
        check({name, "_any"}, {3'b0, det_any}, {3'b0, |v});
        check({name, "_all"}, {3'b0, det_all}, {3'b0, &v});
    endtask

    typedef struct {
        logic         rst;
        logic [L-1:0] req;
        logic [L-1:0] pres;
        int           cycles;
        logic [L-1:0] ack;
        logic [L-1:0] vld;
        logic [L-1:0] bsy;
    } vec_t;

    vec_t vecs[16];

    initial begin
        // Reset behaviour, full-presence detect, and mixed presence with retry.
        vecs[0]  = '{1'b1, 4'h0, 4'h0, 3, 4'h0, 4'h0, 4'h0};
        vecs[1]  = '{1'b0, 4'h0, 4'hF, 1, 4'h0, 4'h0, 4'h0};
        vecs[2]  = '{1'b1, 4'hF, 4'hF, 3, 4'h0, 4'h0, 4'h0};
        vecs[3]  = '{1'b0, 4'h0, 4'hF, 1, 4'h0, 4'h0, 4'h0};
        vecs[4]  = '{1'b0, 4'hF, 4'hF, 1, 4'h0, 4'h0, 4'hF};
        vecs[5]  = '{1'b0, 4'hF, 4'hF, 7, 4'h0, 4'h0, 4'hF};
        vecs[6]  = '{1'b0, 4'hF, 4'hF, 1, 4'hF, 4'hF, 4'h0};
        vecs[7]  = '{1'b0, 4'hF, 4'hF, 1, 4'h0, 4'hF, 4'h0};
        vecs[8]  = '{1'b0, 4'h0, 4'hF, 1, 4'h0, 4'hF, 4'h0};
        vecs[9]  = '{1'b0, 4'hF, 4'h5, 1, 4'h0, 4'hF, 4'hF};
        vecs[10] = '{1'b0, 4'hF, 4'h5, 7, 4'h0, 4'hF, 4'hF};
        vecs[11] = '{1'b0, 4'hF, 4'h5, 1, 4'h5, 4'hF, 4'hA};
        vecs[12] = '{1'b0, 4'hF, 4'h5, 7, 4'h0, 4'hF, 4'hA};
        vecs[13] = '{1'b0, 4'hF, 4'h5, 1, 4'hA, 4'h5, 4'h0};
        vecs[14] = '{1'b0, 4'hF, 4'h5, 1, 4'h0, 4'h5, 4'h0};
        vecs[15] = '{1'b0, 4'h0, 4'h5, 1, 4'h0, 4'h5, 4'h0};

        for (int i = 0; i < 16; i++) begin
            rst        = vecs[i].rst;
            rx_det_req = vecs[i].req;
            rx_present = vecs[i].pres;
            step(vecs[i].cycles);
            expect_out($sformatf("vec%0d", i), vecs[i].ack, vecs[i].vld, vecs[i].bsy);
        end

        // Lane 1 gains a receiver partway through its retry attempt.
        rx_det_req = 4'b0010;
        rx_present = 4'b0000;
        step(1);
        step(11);
        rx_present = 4'b0010;
        step(4);
        expect_out("late_pres_wait", 4'b0000, 4'b0101, 4'b0010);
        step(1);
        expect_out("late_pres_ack", 4'b0010, 4'b0111, 4'b0000);
        rx_det_req = 4'b0000;
        step(1);

        // Lane 2 aborted at cnt=5, then re-requested after one low cycle.
        rx_det_req = 4'b0100;
        rx_present = 4'b0000;
        step(6);
        expect_out("abort_pre", 4'b0000, 4'b0111, 4'b0100);
        rx_det_req = 4'b0000;
        step(1);
        expect_out("abort", 4'b0000, 4'b0111, 4'b0000);
        rx_det_req = 4'b0100;
        step(16);
        expect_out("rereq_wait", 4'b0000, 4'b0111, 4'b0100);
        step(1);
        expect_out("rereq_ack", 4'b0100, 4'b0011, 4'b0000);
        rx_det_req = 4'b0000;
        step(1);

        // Reset mid-charge, then a fresh sequence with req held through release.
        rx_det_req = 4'hF;
        rx_present = 4'hF;
        step(5);
        rst = 1'b1;
        step(1);
        expect_out("rst_mid", 4'h0, 4'h0, 4'h0);
        step(2);
        rst = 1'b0;
        step(1);
        expect_out("post_rst_start", 4'h0, 4'h0, 4'hF);
        step(7);
        expect_out("post_rst_wait", 4'h0, 4'h0, 4'hF);
        step(1);
        expect_out("post_rst_ack", 4'hF, 4'hF, 4'h0);
        rx_det_req = 4'h0;
        step(1);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            for (int l = 0; l < L; l++) begin
                if (rx_det_req[l]) rx_det_req[l] = ($urandom_range(39) != 0);
                else               rx_det_req[l] = ($urandom_range(3) == 0);
            end
            rx_present = 4'($urandom);
            rst        = ($urandom_range(499) == 0);
            step(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
